elevator_request_scheduler: RTL and testbench
=============================================

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1, max 16).
REQ-002 SHALL have parameter DWELL_CYCLES, default 8, door-hold time per stop in clk cycles (>=1).
REQ-003 SHALL have port clk input 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1, asynchronous and active-low.
REQ-005 SHALL have port call_valid input 1, one-cycle pulse registering a car/hall call.
REQ-006 SHALL have port call_floor input 4, floor number of the call, sampled when call_valid=1.
REQ-007 SHALL have port current_floor input 4, the cab's present floor.
REQ-008 SHALL have port door_open input 1, the cab's door open status, used as the arrival indication.
REQ-009 SHALL have port emer_stop input 1, emergency stop level.
REQ-010 SHALL have port clear_all input 1, synchronous flush of all pending calls.
REQ-011 SHALL have port request_floor output 4, registered target floor for the cab.
REQ-012 SHALL have port request_valid output 1, high when request_floor is a live target.
REQ-013 SHALL have port dir_up output 1, sweep direction (1=up, 0=down).
REQ-014 SHALL have port pending output NUM_FLOORS, one bit per floor with an outstanding call.
REQ-015 SHALL have port door_hold output 1, high while in DWELL.
REQ-016 SHALL have port call_err output 1, one-cycle pulse on a rejected call.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE_UP, SERVE_DOWN, DWELL, HALT.
REQ-018 SHALL set pending[call_floor] on call_valid when call_floor<NUM_FLOORS; visible on pending next cycle.
REQ-019 SHALL ignore call_valid with call_floor>=NUM_FLOORS and pulse call_err for exactly one cycle.
REQ-020 SHALL define arrival as state SERVE_UP/SERVE_DOWN with current_floor==request_floor and door_open=1; arrival clears pending[request_floor] and enters DWELL.
REQ-021 SHALL give clear priority over set when a call and an arrival clear target the same floor in the same cycle (bit ends 0).
REQ-022 In IDLE: pending==0 -> stay; pending[current_floor]=1 -> clear bit, DWELL; else any bit above current_floor -> SERVE_UP, dir_up=1; else SERVE_DOWN, dir_up=0.
REQ-023 In SERVE_UP, request_floor SHALL be the lowest pending floor above current_floor; when none remains above, go SERVE_DOWN if any below, else IDLE.
REQ-024 In SERVE_DOWN, request_floor SHALL be the highest pending floor below current_floor; when none remains below, go SERVE_UP if any above, else IDLE.
REQ-025 request_floor/request_valid SHALL be registered, reflecting pending/current_floor with one-cycle latency; request_valid=1 only in SERVE_UP/SERVE_DOWN.
REQ-026 In DWELL, the counter SHALL load DWELL_CYCLES-1 on entry and decrement each cycle; at 0, the FSM re-evaluates continuing current dir_up first, then reverse, then IDLE.
REQ-027 A new call for current_floor arriving during DWELL SHALL be cleared without extending the dwell.
REQ-028 emer_stop=1 SHALL force HALT from any state next cycle; in HALT request_valid=0, door_hold=0, pending retained and calls still accepted; emer_stop=0 -> IDLE.
REQ-029 clear_all SHALL zero pending next cycle, overriding a simultaneous call; if in SERVE_*, go IDLE.
REQ-030 emer_stop SHALL take priority over clear_all, arrival and DWELL expiry.

Reset
REQ-031 On reset low, SHALL asynchronously set state=IDLE, pending=0, request_floor=0, request_valid=0, dir_up=1, door_hold=0, call_err=0, dwell counter=0.
REQ-032 Release SHALL be treated as synchronous to clk; reset mid-sweep discards all pending calls.

Verification
REQ-033 current_floor=0, calls 3 then 7 -> SERVE_UP, request_floor=3; at floor 3 with door_open -> door_hold 8 cycles, pending=0x080, request_floor=7.
REQ-034 current_floor=5, dir_up=1, pending {2,8} -> request_floor=8 first, then after DWELL request_floor=2, dir_up=0.
REQ-035 call_floor=12 -> call_err pulses one cycle, pending unchanged.
REQ-036 SERVE_UP toward 6, emer_stop=1 -> HALT, request_valid=0, pending kept; emer_stop=0 -> IDLE then SERVE_UP with request_floor=6.
REQ-037 arrival at 4 with call_floor=4 same cycle -> pending[4]=0; clear_all with pending=0x3FF -> pending=0, state IDLE.
REQ-038 reset low during DWELL -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// Single-cab SCAN scheduler: latches floor calls, sweeps up/down toward the nearest
// pending floor in the travel direction, holds the door at each stop, and halts on emergency.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [3:0]            call_floor,
  input  logic [3:0]            current_floor,
  input  logic                  door_open,
  input  logic                  emer_stop,
  input  logic                  clear_all,
  output logic [3:0]            request_floor,
  output logic                  request_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_hold,
  output logic                  call_err
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_UP,
    SERVE_DOWN,
    DWELL,
    HALT
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [3:0]            request_floor_q, request_floor_d;
  logic                  request_valid_q, request_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_hold_q, door_hold_d;
  logic                  call_err_q, call_err_d;
  logic [CNT_W-1:0]      dwell_cnt_q, dwell_cnt_d;

  logic [NUM_FLOORS-1:0] call_mask, cur_mask, req_mask, clr_mask;
  logic                  call_in_range, cur_pending, above_any, below_any, arrival, flush;
  logic [3:0]            lowest_above, highest_below;

  // Floor decodes and nearest-pending search; out-of-range floors simply match no bit.
  always_comb begin
    call_mask     = '0;
    cur_mask      = '0;
    req_mask      = '0;
    call_in_range = 1'b0;
    above_any     = 1'b0;
    below_any     = 1'b0;
    lowest_above  = '0;
    highest_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (call_floor == 4'(i)) begin
        call_in_range = 1'b1;
        call_mask[i]  = call_valid;
      end
      if (current_floor == 4'(i))   cur_mask[i] = 1'b1;
      if (request_floor_q == 4'(i)) req_mask[i] = 1'b1;
      if (pending_q[i] && (4'(i) > current_floor)) begin
        above_any    = 1'b1;
        lowest_above = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (4'(i) < current_floor)) begin
        below_any     = 1'b1;
        highest_below = 4'(i);
      end
    end
  end

  assign cur_pending = |(pending_q & cur_mask);
  assign arrival     = ((state_q == SERVE_UP) || (state_q == SERVE_DOWN)) && request_valid_q &&
                       (current_floor == request_floor_q) && door_open;

  always_comb begin
    state_d         = state_q;
    request_floor_d = request_floor_q;
    dir_up_d        = dir_up_q;
    dwell_cnt_d     = dwell_cnt_q;
    clr_mask        = '0;
    flush           = 1'b0;
    call_err_d      = call_valid && !call_in_range;

    if (emer_stop) begin
      state_d = HALT;
    end else if (clear_all) begin
      flush = 1'b1;
      if (state_q == DWELL) begin
        if (dwell_cnt_q == '0) state_d = IDLE;
        else                   dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cur_pending) begin
            clr_mask    = cur_mask;
            state_d     = DWELL;
            dwell_cnt_d = DWELL_LOAD;
          end else if (above_any) begin
            state_d         = SERVE_UP;
            dir_up_d        = 1'b1;
            request_floor_d = lowest_above;
          end else if (below_any) begin
            state_d         = SERVE_DOWN;
            dir_up_d        = 1'b0;
            request_floor_d = highest_below;
          end
        end
        SERVE_UP, SERVE_DOWN: begin
          if (arrival) begin
            clr_mask    = req_mask;
            state_d     = DWELL;
            dwell_cnt_d = DWELL_LOAD;
          end else if ((state_q == SERVE_UP) && above_any) begin
            request_floor_d = lowest_above;
          end else if ((state_q == SERVE_DOWN) && below_any) begin
            request_floor_d = highest_below;
          end else if (above_any) begin
            state_d         = SERVE_UP;
            dir_up_d        = 1'b1;
            request_floor_d = lowest_above;
          end else if (below_any) begin
            state_d         = SERVE_DOWN;
            dir_up_d        = 1'b0;
            request_floor_d = highest_below;
          end else begin
            state_d = IDLE;
          end
        end
        DWELL: begin
          // Calls for the floor we are parked at are absorbed without restarting the timer.
          clr_mask = cur_mask;
          if (dwell_cnt_q != '0) begin
            dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
          end else if ((dir_up_q && above_any) || (!dir_up_q && !below_any && above_any)) begin
            state_d         = SERVE_UP;
            dir_up_d        = 1'b1;
            request_floor_d = lowest_above;
          end else if (below_any) begin
            state_d         = SERVE_DOWN;
            dir_up_d        = 1'b0;
            request_floor_d = highest_below;
          end else begin
            state_d = IDLE;
          end
        end
        HALT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    pending_d       = flush ? '0 : ((pending_q | call_mask) & ~clr_mask);
    request_valid_d = (state_d == SERVE_UP) || (state_d == SERVE_DOWN);
    door_hold_d     = (state_d == DWELL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      request_floor_q <= '0;
      request_valid_q <= 1'b0;
      dir_up_q        <= 1'b1;
      door_hold_q     <= 1'b0;
      call_err_q      <= 1'b0;
      dwell_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      request_floor_q <= request_floor_d;
      request_valid_q <= request_valid_d;
      dir_up_q        <= dir_up_d;
      door_hold_q     <= door_hold_d;
      call_err_q      <= call_err_d;
      dwell_cnt_q     <= dwell_cnt_d;
    end
  end

  assign request_floor = request_floor_q;
  assign request_valid = request_valid_q;
  assign dir_up        = dir_up_q;
  assign pending       = pending_q;
  assign door_hold     = door_hold_q;
  assign call_err      = call_err_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: each stimulus step queues the outputs
// it should produce, and the queue is drained against the DUT one time unit after the edge.
module tb_elevator_request_scheduler;

  localparam int NF = 10;
  localparam int DW = 8;

  localparam int F_RV   = 0;
  localparam int F_RF   = 1;
  localparam int F_DIR  = 2;
  localparam int F_PEND = 3;
  localparam int F_DH   = 4;
  localparam int F_ERR  = 5;

  typedef struct {
    string       tag;
    int          field;
    logic [31:0] value;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          call_valid;
  logic [3:0]    call_floor;
  logic [3:0]    current_floor;
  logic          door_open;
  logic          emer_stop;
  logic          clear_all;
  logic [3:0]    request_floor;
  logic          request_valid;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          door_hold;
  logic          call_err;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .door_open(door_open), .emer_stop(emer_stop),
    .clear_all(clear_all), .request_floor(request_floor), .request_valid(request_valid),
    .dir_up(dir_up), .pending(pending), .door_hold(door_hold), .call_err(call_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [31:0] observe(input int field);
    case (field)
      F_RV:    return 32'(request_valid);
      F_RF:    return 32'(request_floor);
      F_DIR:   return 32'(dir_up);
      F_PEND:  return 32'(pending);
      F_DH:    return 32'(door_hold);
      default: return 32'(call_err);
    endcase
  endfunction

  task automatic pushExp(input string tag, input int field, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic compareNow();
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, observe(e.field), e.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compareNow();
  endtask

  task automatic applyStimulus(input logic cv, input logic [3:0] cf, input logic [3:0] cur,
                               input logic door, input logic emer, input logic clr);
    call_valid    = cv;
    call_floor    = cf;
    current_floor = cur;
    door_open     = door;
    emer_stop     = emer;
    clear_all     = clr;
  endtask

  task automatic expectReset(input string tag);
    pushExp({tag, "_rv"}, F_RV, 0);
    pushExp({tag, "_rf"}, F_RF, 0);
    pushExp({tag, "_dir"}, F_DIR, 1);
    pushExp({tag, "_pend"}, F_PEND, 0);
    pushExp({tag, "_dh"}, F_DH, 0);
    pushExp({tag, "_err"}, F_ERR, 0);
  endtask

  // Holds the door for the remaining DW-1 cycles after the arrival cycle has been checked.
  task automatic holdDwell(input string tag, input logic [3:0] cur);
    for (int k = 1; k < DW; k++) begin
      applyStimulus(0, 0, cur, 0, 0, 0);
      pushExp(tag, F_DH, 1);
      tick();
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #12;
    expectReset("rst");
    compareNow();
    reset = 1'b1;

    // Calls 3 then 7 from floor 0: serve 3, dwell, then continue up to 7.
    applyStimulus(1, 3, 0, 0, 0, 0); pushExp("a_pend3", F_PEND, 32'h008); pushExp("a_rv0", F_RV, 0); tick();
    applyStimulus(1, 7, 0, 0, 0, 0); pushExp("a_pend37", F_PEND, 32'h088);
    pushExp("a_rv1", F_RV, 1); pushExp("a_rf3", F_RF, 3); pushExp("a_dirup", F_DIR, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); pushExp("a_rf3b", F_RF, 3); tick();
    applyStimulus(0, 0, 3, 1, 0, 0); pushExp("a_arr_dh", F_DH, 1);
    pushExp("a_arr_pend", F_PEND, 32'h080); pushExp("a_arr_rv", F_RV, 0); tick();
    holdDwell("a_dwell", 3);
    applyStimulus(0, 0, 3, 0, 0, 0); pushExp("a_exp_dh", F_DH, 0); pushExp("a_exp_rv", F_RV, 1);
    pushExp("a_exp_rf7", F_RF, 7); pushExp("a_exp_pend", F_PEND, 32'h080); tick();
    applyStimulus(1, 9, 7, 1, 0, 0); pushExp("a_arr7_pend", F_PEND, 32'h200); pushExp("a_arr7_dh", F_DH, 1); tick();
    applyStimulus(0, 0, 7, 0, 0, 0); pushExp("a_dw7", F_DH, 1); tick();
    #2;
    reset = 1'b0;
    #1;
    expectReset("async");
    compareNow();
    #1;
    reset = 1'b1;

    // Floor 5 heading up with {2,8} pending: 8 first, then reverse to 2, then idle.
    applyStimulus(1, 2, 5, 0, 1, 0); pushExp("b_halt_rv", F_RV, 0); pushExp("b_pend2", F_PEND, 32'h004); tick();
    applyStimulus(1, 8, 5, 0, 1, 0); pushExp("b_pend28", F_PEND, 32'h104); tick();
    applyStimulus(0, 0, 5, 0, 0, 0); pushExp("b_idle_rv", F_RV, 0); pushExp("b_idle_dh", F_DH, 0); tick();
    applyStimulus(0, 0, 5, 0, 0, 0); pushExp("b_rv", F_RV, 1); pushExp("b_rf8", F_RF, 8); pushExp("b_dirup", F_DIR, 1); tick();
    applyStimulus(0, 0, 8, 1, 0, 0); pushExp("b_arr_dh", F_DH, 1); pushExp("b_arr_pend", F_PEND, 32'h004); tick();
    holdDwell("b_dwell", 8);
    applyStimulus(0, 0, 8, 0, 0, 0); pushExp("b_rf2", F_RF, 2); pushExp("b_dirdn", F_DIR, 0); pushExp("b_rv2", F_RV, 1); tick();
    applyStimulus(0, 0, 2, 1, 0, 0); pushExp("b_arr2_pend", F_PEND, 0); pushExp("b_arr2_dh", F_DH, 1); tick();
    holdDwell("b_dwell2", 2);
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("b_end_dh", F_DH, 0); pushExp("b_end_rv", F_RV, 0); tick();

    // Out-of-range calls are rejected with a single-cycle error pulse.
    applyStimulus(1, 12, 2, 0, 0, 0); pushExp("c_err12", F_ERR, 1); pushExp("c_pend12", F_PEND, 0); tick();
    applyStimulus(1, 10, 2, 0, 0, 0); pushExp("c_err10", F_ERR, 1); pushExp("c_pend10", F_PEND, 0); tick();
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("c_err_off", F_ERR, 0); tick();

    // Emergency stop mid-sweep toward 6, calls accepted while halted, then resume.
    applyStimulus(1, 6, 2, 0, 0, 0); pushExp("d_pend6", F_PEND, 32'h040); pushExp("d_err0", F_ERR, 0); tick();
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("d_rf6", F_RF, 6); pushExp("d_rv1", F_RV, 1); pushExp("d_dirup", F_DIR, 1); tick();
    applyStimulus(0, 0, 2, 0, 1, 0); pushExp("d_halt_rv", F_RV, 0); pushExp("d_halt_pend", F_PEND, 32'h040); pushExp("d_halt_dh", F_DH, 0); tick();
    applyStimulus(1, 9, 2, 0, 1, 0); pushExp("d_halt_call", F_PEND, 32'h240); tick();
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("d_idle_rv", F_RV, 0); tick();
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("d_resume_rv", F_RV, 1); pushExp("d_resume_rf", F_RF, 6); tick();

    // Retarget to a nearer call, arrival colliding with a call to the same floor, fill and flush.
    applyStimulus(1, 4, 2, 0, 0, 0); pushExp("e_pend", F_PEND, 32'h250); pushExp("e_rf6", F_RF, 6); tick();
    applyStimulus(0, 0, 2, 0, 0, 0); pushExp("e_rf4", F_RF, 4); tick();
    applyStimulus(1, 4, 4, 1, 0, 0); pushExp("e_clr_pri", F_PEND, 32'h240); pushExp("e_dh", F_DH, 1); tick();
    applyStimulus(1, 4, 4, 0, 0, 0); pushExp("e_dwell_call", F_PEND, 32'h240); pushExp("e_dh2", F_DH, 1); tick();
    for (int i = 0; i < NF; i++) begin
      applyStimulus(1, 4'(i), 4, 0, 1, 0);
      pushExp("e_fill_dh", F_DH, 0);
      tick();
    end
    pushExp("e_full", F_PEND, 32'h3FF);
    compareNow();
    applyStimulus(0, 0, 4, 0, 0, 1); pushExp("e_flush", F_PEND, 0); pushExp("e_flush_rv", F_RV, 0); tick();
    applyStimulus(0, 0, 4, 0, 0, 0); pushExp("e_idle_rv", F_RV, 0); pushExp("e_idle_dh", F_DH, 0); tick();

    // Flush during a sweep beats a simultaneous call; emergency stop beats flush.
    applyStimulus(1, 7, 0, 0, 0, 0); pushExp("f_pend7", F_PEND, 32'h080); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); pushExp("f_rv", F_RV, 1); pushExp("f_rf7", F_RF, 7); tick();
    applyStimulus(1, 3, 0, 0, 0, 1); pushExp("f_flush_call", F_PEND, 0); pushExp("f_flush_rv", F_RV, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); pushExp("f_stay_idle", F_RV, 0); tick();
    applyStimulus(1, 5, 0, 0, 0, 0); pushExp("f_pend5", F_PEND, 32'h020); tick();
    applyStimulus(0, 0, 0, 0, 1, 1); pushExp("f_emer_pri", F_PEND, 32'h020); pushExp("f_emer_rv", F_RV, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 1); pushExp("f_flush2", F_PEND, 0); tick();

    // A call at the floor the cab is already on opens the door straight from idle.
    applyStimulus(1, 0, 0, 0, 0, 0); pushExp("g_pend0", F_PEND, 32'h001); tick();
    applyStimulus(0, 0, 0, 0, 0, 0); pushExp("g_dh", F_DH, 1); pushExp("g_pend", F_PEND, 0); pushExp("g_rv", F_RV, 0); tick();
    pulseReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectReset("final");
    compareNow();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
